// File: rtl/des_pkg.sv
// Shared constants, tables and FSM state type for the iterative DES round sequencer.
package des_pkg;

    localparam int HALF_W    = 32;
    localparam int KEY_W     = 48;
    localparam int CD_W      = 56;
    localparam int BLOCK_W   = 64;
    localparam int CD_HALF_W = CD_W / 2;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } des_state_e;

    // Per-round left-rotation amounts of the C and D key halves, round 1 first.
    localparam logic [1:0] SHIFT [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-2 selection, 1-based DES bit numbering with bit 1 = MSB of C||D.
    localparam logic [5:0] PC2 [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Only rotations of 1 or 2 ever occur; any other amount is treated as 1.
    function automatic logic [CD_HALF_W-1:0] rotl28(input logic [CD_HALF_W-1:0] x,
                                                    input logic [1:0]           n);
        return (n == 2'd2) ? {x[CD_HALF_W-3:0], x[CD_HALF_W-1:CD_HALF_W-2]}
                           : {x[CD_HALF_W-2:0], x[CD_HALF_W-1]};
    endfunction

    function automatic logic [CD_HALF_W-1:0] rotr28(input logic [CD_HALF_W-1:0] x,
                                                    input logic [1:0]           n);
        return (n == 2'd2) ? {x[1:0], x[CD_HALF_W-1:2]}
                           : {x[0], x[CD_HALF_W-1:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 permutation: selects the 48-bit round subkey from the 56-bit C||D register.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]  cd,
    output logic [KEY_W-1:0] subkey
);

    logic [5:0] tap;
    logic [5:0] src_idx;
    logic [5:0] dst_idx;

    // Output bit 1 (MSB) takes C||D bit PC2[0]; both numberings count from the MSB.
    always_comb begin
        subkey  = '0;
        tap     = '0;
        src_idx = '0;
        dst_idx = '0;
        for (int i = 0; i < KEY_W; i++) begin
            tap             = 6'(i);
            dst_idx         = 6'(KEY_W - 1) - tap;
            src_idx         = 6'(CD_W) - PC2[tap];
            subkey[dst_idx] = cd[src_idx];
        end
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: 16 Feistel rounds, one per clock, around an external
// f-function, with on-the-fly encrypt/decrypt subkey generation and a valid/ready output.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               decrypt_i,
    input  logic [HALF_W-1:0]  l_i,
    input  logic [HALF_W-1:0]  r_i,
    input  logic [CD_W-1:0]    cd_i,
    output logic [HALF_W-1:0]  f_r_o,
    output logic [KEY_W-1:0]   f_subkey_o,
    input  logic [HALF_W-1:0]  f_result_i,
    output logic [3:0]         round_o,
    output logic               busy_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [BLOCK_W-1:0] out_block_o
);

    localparam int               CNT_W      = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    des_state_e           state_q;
    des_state_e           state_d;
    logic                 load_en;
    logic                 round_en;

    logic                 dec_q;
    logic [HALF_W-1:0]    l_q;
    logic [HALF_W-1:0]    r_q;
    logic [CD_HALF_W-1:0] c_q;
    logic [CD_HALF_W-1:0] d_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [CNT_W-1:0]     cnt_inc;
    logic [1:0]           enc_shift;
    logic [1:0]           dec_shift;
    logic [CD_HALF_W-1:0] c_load;
    logic [CD_HALF_W-1:0] d_load;
    logic [CD_HALF_W-1:0] c_step;
    logic [CD_HALF_W-1:0] d_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        round_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    load_en = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                round_en = 1'b1;
                if (cnt_q == LAST_ROUND) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Encrypt walks C/D forward ahead of the next round; decrypt walks it backward from C16D16.
    // On the final round the index wraps and the resulting C/D value is never used.
    always_comb begin
        cnt_inc   = cnt_q + 1'b1;
        enc_shift = SHIFT[cnt_inc];
        dec_shift = SHIFT[LAST_ROUND - cnt_q];
        c_load    = cd_i[CD_W-1:CD_HALF_W];
        d_load    = cd_i[CD_HALF_W-1:0];
        if (dec_q) begin
            c_step = rotr28(c_q, dec_shift);
            d_step = rotr28(d_q, dec_shift);
        end else begin
            c_step = rotl28(c_q, enc_shift);
            d_step = rotl28(d_q, enc_shift);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
            l_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else if (load_en) begin
            dec_q <= decrypt_i;
            l_q   <= l_i;
            r_q   <= r_i;
            cnt_q <= '0;
            if (decrypt_i) begin
                c_q <= c_load;
                d_q <= d_load;
            end else begin
                c_q <= rotl28(c_load, SHIFT[0]);
                d_q <= rotl28(d_load, SHIFT[0]);
            end
        end else if (round_en) begin
            l_q <= r_q;
            r_q <= l_q ^ f_result_i;
            c_q <= c_step;
            d_q <= d_step;
            if (cnt_q != LAST_ROUND) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (f_subkey_o)
    );

    assign f_r_o       = r_q;
    assign round_o     = 4'(cnt_q);
    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q == ROUND);
    assign out_valid_o = (state_q == DONE);
    assign out_block_o = {r_q, l_q};

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: a reference DES f-function is attached and output blocks
// are checked against a scoreboard of expected results.
module tb_des_round_ctrl;

    localparam logic [31:0] ENC_L   = 32'hCC00CCFF;
    localparam logic [31:0] ENC_R   = 32'hF0AAF0AA;
    localparam logic [31:0] DEC_L   = 32'h0A4CD995;
    localparam logic [31:0] DEC_R   = 32'h43423234;
    localparam logic [55:0] KEY_CD  = 56'hF0CCAAF556678F;
    localparam logic [63:0] ENC_OUT = 64'h0A4CD99543423234;
    localparam logic [63:0] DEC_OUT = 64'hCC00CCFFF0AAF0AA;

    localparam int SBOX [0:511] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
        0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
        15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
        3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
        13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
        13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
        1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
        13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
        3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
        14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
        11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
        10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
        4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
        13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
        6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
        1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
        2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
    };

    localparam int P_TAB [0:31] = '{
        16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25
    };

    localparam int PC2_TAB [0:47] = '{
        14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
        26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
        51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32
    };

    // Cumulative left rotation of C0/D0 that yields C_n/D_n for n = 1..16.
    localparam int CUM_SHIFT [0:15] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        decrypt = 1'b0;
    logic [31:0] l_in = '0;
    logic [31:0] r_in = '0;
    logic [55:0] cd_in = '0;
    logic [31:0] f_r;
    logic [47:0] f_subkey;
    logic [31:0] f_result;
    logic [3:0]  round_idx;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_block;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        int          src;
        int          row;
        int          col;
        for (int b = 0; b < 48; b++) begin
            src = 4 * (b / 6) + (b % 6);
            if (src == 0) src = 32;
            else if (src == 33) src = 1;
            e[47-b] = r[32-src];
        end
        e = e ^ k;
        for (int g = 0; g < 8; g++) begin
            six = e[47-6*g -: 6];
            row = int'({six[5], six[0]});
            col = int'(six[4:1]);
            s[31-4*g -: 4] = 4'(SBOX[g*64 + row*16 + col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
        return p;
    endfunction

    function automatic logic [47:0] ref_key(input logic [55:0] cd0, input int n);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] k;
        c = cd0[55:28];
        d = cd0[27:0];
        for (int i = 0; i < CUM_SHIFT[n-1]; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_TAB[i]];
        return k;
    endfunction

    assign f_result = f_model(f_r, f_subkey);

    des_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .decrypt_i   (decrypt),
        .l_i         (l_in),
        .r_i         (r_in),
        .cd_i        (cd_in),
        .f_r_o       (f_r),
        .f_subkey_o  (f_subkey),
        .f_result_i  (f_result),
        .round_o     (round_idx),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_block_o (out_block)
    );

    // Drives one transfer and returns at the falling edge after the transfer edge.
    task automatic start_block(input logic [31:0] l, input logic [31:0] r,
                               input logic dec, input logic [63:0] expv);
        @(negedge clk);
        l_in = l;
        r_in = r;
        cd_in = KEY_CD;
        decrypt = dec;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (round_idx !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_round got %0d want 0", round_idx); end
        tests_run++; if (f_subkey !== 48'h0) begin tests_failed++; $display("[TB] FAIL reset_subkey got %h want 0", f_subkey); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (f_r !== 32'h0) begin tests_failed++; $display("[TB] FAIL post_reset_f_r got %h want 0", f_r); end
        tests_run++; if (out_block !== 64'h0) begin tests_failed++; $display("[TB] FAIL post_reset_block got %h want 0", out_block); end
    endtask

    task automatic test_encrypt;
        logic [63:0] expv;
        start_block(ENC_L, ENC_R, 1'b0, ENC_OUT);
        decrypt = 1'b1;
        tests_run++; if (f_subkey !== 48'h1B02EFFC7072) begin tests_failed++; $display("[TB] FAIL enc_k1 got %h want 1b02effc7072", f_subkey); end
        for (int k = 0; k < 16; k++) begin
            tests_run++; if (busy !== 1'b1 || out_valid !== 1'b0 || round_idx !== 4'(k)) begin tests_failed++; $display("[TB] FAIL enc_round_state busy=%b valid=%b round=%0d want 1/0/%0d", busy, out_valid, round_idx, k); end
            tests_run++; if (f_subkey !== ref_key(KEY_CD, k + 1)) begin tests_failed++; $display("[TB] FAIL enc_subkey round %0d got %h want %h", k, f_subkey, ref_key(KEY_CD, k + 1)); end
            @(negedge clk);
        end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL enc_latency out_valid got %b want 1", out_valid); end
        expv = exp_q.pop_front();
        tests_run++; if (out_block !== expv) begin tests_failed++; $display("[TB] FAIL enc_block got %h want %h", out_block, expv); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        decrypt = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL enc_release valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_decrypt;
        logic [63:0] expv;
        start_block(DEC_L, DEC_R, 1'b1, DEC_OUT);
        decrypt = 1'b0;
        tests_run++; if (f_subkey !== 48'hCB3D8B0E17F5) begin tests_failed++; $display("[TB] FAIL dec_k16 got %h want cb3d8b0e17f5", f_subkey); end
        for (int k = 0; k < 16; k++) begin
            tests_run++; if (f_subkey !== ref_key(KEY_CD, 16 - k)) begin tests_failed++; $display("[TB] FAIL dec_subkey_order round %0d got %h want %h", k, f_subkey, ref_key(KEY_CD, 16 - k)); end
            @(negedge clk);
        end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL dec_latency out_valid got %b want 1", out_valid); end
        expv = exp_q.pop_front();
        tests_run++; if (out_block !== expv) begin tests_failed++; $display("[TB] FAIL dec_block got %h want %h", out_block, expv); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        bit          ok;
        logic [63:0] held;
        logic [63:0] expv;
        start_block(ENC_L, ENC_R, 1'b0, ENC_OUT);
        wait_out(40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL bp_timeout out_valid got 0 want 1"); end
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_hold_flags valid=%b ready=%b want 1/0", out_valid, in_ready); end
            tests_run++; if (out_block !== held) begin tests_failed++; $display("[TB] FAIL bp_hold_block got %h want %h", out_block, held); end
            if (i == 2) begin
                l_in = DEC_L;
                r_in = DEC_R;
                decrypt = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        expv = exp_q.pop_front();
        tests_run++; if (out_block !== expv) begin tests_failed++; $display("[TB] FAIL bp_block got %h want %h", out_block, expv); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    endtask

    task automatic test_reset_mid_run;
        bit          ok;
        bit          found;
        logic [63:0] expv;
        found = 1'b0;
        start_block(ENC_L, ENC_R, 1'b0, ENC_OUT);
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b1 && round_idx === 4'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++; if (!found) begin tests_failed++; $display("[TB] FAIL mid_reach_round7 got %0d want 7", round_idx); end
        rst = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_flags ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid); end
        tests_run++; if ({f_r, f_subkey, round_idx, out_block} !== '0) begin tests_failed++; $display("[TB] FAIL mid_reset_data r=%h k=%h rnd=%0d blk=%h want 0", f_r, f_subkey, round_idx, out_block); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        start_block(ENC_L, ENC_R, 1'b0, ENC_OUT);
        wait_out(40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL mid_rerun_timeout out_valid got 0 want 1"); end
        expv = exp_q.pop_front();
        tests_run++; if (out_block !== expv) begin tests_failed++; $display("[TB] FAIL mid_rerun_block got %h want %h", out_block, expv); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int          sent;
        int          got;
        int          xfer_cyc [0:3];
        logic [63:0] expv;
        sent = 0;
        got = 0;
        cd_in = KEY_CD;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && got < 4; c++) begin
            @(negedge clk);
            if (sent < 4) begin
                l_in = sent[0] ? DEC_L : ENC_L;
                r_in = sent[0] ? DEC_R : ENC_R;
                decrypt = sent[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                expv = exp_q.pop_front();
                tests_run++; if (out_block !== expv) begin tests_failed++; $display("[TB] FAIL b2b_block %0d got %h want %h", got, out_block, expv); end
                got++;
            end
            if (in_ready === 1'b1 && in_valid === 1'b1) begin
                exp_q.push_back(sent[0] ? DEC_OUT : ENC_OUT);
                xfer_cyc[sent] = cyc;
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests_run++; if (got != 4) begin tests_failed++; $display("[TB] FAIL b2b_timeout got %0d results want 4", got); end
        for (int i = 1; i < 4; i++) begin
            tests_run++; if (xfer_cyc[i] - xfer_cyc[i-1] != 18) begin tests_failed++; $display("[TB] FAIL b2b_spacing %0d got %0d want 18", i, xfer_cyc[i] - xfer_cyc[i-1]); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
